fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Multi-cycle instruction-fetch controller that owns the program counter and sequences fetches from instruction memory to the decode stage. It issues one outstanding request at a time over a valid/ready request channel and accepts a fixed-latency-free response. It presents the fetched instruction with its PC and PC+4 to decode under valid/ready. It applies branch/jump redirects, which take priority over every other event.

## Interface
- RESET_PC, 32'hBFC00000: PC loaded on reset.
- COUNT_W, 32: width of the fetch counter.

- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  fetch address; equals the PC register.
- imem_rsp_valid  in  1  response data valid; at most one per accepted request, earliest one cycle after acceptance.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst_data  out  32  captured instruction.
- inst_pc  out  32  address of inst_data.
- inst_pc_plus4  out  32  inst_pc + 4, modulo 2^32.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  redirect target.
- misalign_err  out  1  one-cycle pulse when a redirect target had bits [1:0] != 0.
- fetch_count  out  COUNT_W  number of instructions consumed by decode; wraps.

## Operation
- State register states: BOOT, REQ, WAIT, HOLD.
- Other registers: pc (32), drop flag (1).
- imem_req_valid = (state==REQ).
- inst_valid = (state==HOLD).
- Redirect target is redirect_pc with bits [1:0] forced to 0. Every redirect loads pc <= target.
- **BOOT:** go to REQ. A redirect here loads pc; the next state is still REQ.
- **REQ, with redirect:**
  - imem_req_ready=1: the request is accepted with the old address. Load pc, set drop=1, go to WAIT.
  - imem_req_ready=0: load pc and stay in REQ. The address may change while the request is unaccepted.
- **REQ, without redirect:** imem_req_ready=1 goes to WAIT; otherwise stay in REQ.
- **WAIT, imem_rsp_valid=1:**
  - If drop=1 or redirect_valid=1: discard the data, clear drop, go to REQ. A redirect in the same cycle loads pc.
  - Otherwise: inst_data <= imem_rsp_data, inst_pc <= pc, inst_pc_plus4 <= pc+4, go to HOLD.
- **WAIT, no response, redirect:** load pc, set drop=1, stay in WAIT.
- **HOLD, redirect:** discard the instruction even if inst_ready=1 (not counted), load pc, go to REQ.
- **HOLD, inst_ready=1 without redirect:** pc <= pc+4 (wraps 0xFFFFFFFC -> 0x00000000), fetch_count += 1, go to REQ.
- **HOLD, otherwise:** all inst_* outputs stay stable.
- misalign_err is registered: it asserts the cycle after a misaligned redirect is sampled, for exactly one cycle per redirect.
- imem_rsp_valid in REQ, HOLD or BOOT is a protocol violation and is ignored.

## Timing
- Reset values:
  - state=BOOT, pc=RESET_PC, drop=0.
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - inst_valid=0, inst_data=0, inst_pc=0, inst_pc_plus4=0.
  - misalign_err=0, fetch_count=0.
- Reset applies immediately (asynchronous) in any state. Any outstanding response after reset release is not expected and is ignored.
- First request: imem_req_valid rises on the first clk edge after rst deasserts, with addr=RESET_PC.
- Best-case throughput, one instruction per 3 cycles:
  - Request accepted in cycle N.
  - Response in N+1.
  - inst_valid in N+2; consumed in N+2.
  - Next request in N+3.
- Redirect sampled in cycle N: imem_req_valid with the target address is visible no later than N+1, or the cycle after the pending response is dropped.
- At most one request is outstanding at any time.

## Test plan
- Reset release, imem_req_ready=1, response one cycle later, inst_ready=1 -> request addresses 0xBFC00000, 0xBFC00004, 0xBFC00008 issued 3 cycles apart; inst_pc/inst_pc_plus4 match; fetch_count=3.
- Hold inst_ready=0 for 5 cycles in HOLD -> inst_valid and inst_data/inst_pc stable, imem_req_valid=0 throughout; fetch_count increments once on release.
- Redirect to 0x80000010 in WAIT, response arrives 2 cycles later with 0xDEADBEEF -> data never reaches inst_data; next request addr=0x80000010.
- Redirect to 0x80000020 in HOLD with inst_ready=1 in the same cycle -> fetch_count unchanged; inst_valid=0 next cycle; imem_req_addr=0x80000020.
- Redirect to 0x80000013 -> imem_req_addr=0x80000010; misalign_err high exactly one cycle.
- Redirect to 0xFFFFFFFC, consume the instruction -> inst_pc_plus4=0x00000000; next request addr=0x00000000.
- Assert rst while in WAIT -> all outputs return to reset values immediately; first request after release is at RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// fetch_if: request/response channel to instruction memory, decode handoff and redirect inputs.
interface fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and runs one-outstanding-request instruction fetch into decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  fetch_if.master            bus,
  output logic               misalign_err,
  output logic [COUNT_W-1:0] fetch_count
);
  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, data_q, data_d, ipc_q, ipc_d, ipc4_q, ipc4_d, tgt;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic drop_q, drop_d, mis_q, mis_d, redir, rsp, consume, capture;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
      ipc4_q  <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = REQ;
      REQ:     state_d = bus.imem_req_ready ? WAIT : REQ;
      WAIT:    state_d = !bus.imem_rsp_valid ? WAIT : (drop_q || bus.redirect_valid) ? REQ : HOLD;
      HOLD:    state_d = (bus.redirect_valid || bus.inst_ready) ? REQ : HOLD;
      default: state_d = BOOT;
    endcase
  end
  always_comb begin
    redir   = bus.redirect_valid;
    rsp     = bus.imem_rsp_valid && state_q == WAIT;
    tgt     = {bus.redirect_pc[31:2], 2'b00};
    consume = state_q == HOLD && bus.inst_ready && !redir;
    capture = rsp && !drop_q && !redir;
    pc_d    = redir ? tgt : consume ? pc_q + 32'd4 : pc_q;
    // a redirect after the request left must swallow its response
    drop_d  = rsp ? 1'b0 : (redir && ((state_q == REQ && bus.imem_req_ready) || state_q == WAIT)) ? 1'b1 : drop_q;
    data_d  = capture ? bus.imem_rsp_data : data_q;
    ipc_d   = capture ? pc_q : ipc_q;
    ipc4_d  = capture ? pc_q + 32'd4 : ipc4_q;
    cnt_d   = cnt_q + COUNT_W'(consume);
    mis_d   = redir && bus.redirect_pc[1:0] != 2'b00;
  end
  always_comb begin
    bus.imem_req_valid = state_q == REQ;
    bus.imem_req_addr  = pc_q;
    bus.inst_valid     = state_q == HOLD;
    bus.inst_data      = data_q;
    bus.inst_pc        = ipc_q;
    bus.inst_pc_plus4  = ipc4_q;
    misalign_err       = mis_q;
    fetch_count        = cnt_q;
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, async reset sequence, and random run against a transaction-level model.
module tb_fetch_sequencer;
  localparam logic [31:0] B = 32'hBFC00000;
  logic clk = 1'b0, rst = 1'b1, misalign_err;
  logic [31:0] fetch_count;
  int checks = 0, errors = 0;
  fetch_if f();
  fetch_sequencer dut (.clk(clk), .rst(rst), .bus(f), .misalign_err(misalign_err), .fetch_count(fetch_count));
  always #5 clk = ~clk;

  typedef struct {
    logic rdy, rsp; logic [31:0] rdata; logic irdy, rv; logic [31:0] rpc;
    logic e_rv; logic [31:0] e_addr; logic e_iv; logic [31:0] e_data, e_pc, e_pc4, e_cnt; logic e_mis;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(logic rdy, logic rsp, logic [31:0] rdata, logic irdy, logic rv, logic [31:0] rpc,
                              logic e_rv, logic [31:0] e_addr, logic e_iv, logic [31:0] e_data,
                              logic [31:0] e_pc, logic [31:0] e_pc4, logic [31:0] e_cnt, logic e_mis);
    vec_t v;
    v.rdy = rdy; v.rsp = rsp; v.rdata = rdata; v.irdy = irdy; v.rv = rv; v.rpc = rpc;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_data = e_data;
    v.e_pc = e_pc; v.e_pc4 = e_pc4; v.e_cnt = e_cnt; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rsp, input logic [31:0] rdata,
                       input logic irdy, input logic rv, input logic [31:0] rpc);
    f.imem_req_ready = rdy; f.imem_rsp_valid = rsp; f.imem_rsp_data = rdata;
    f.inst_ready = irdy; f.redirect_valid = rv; f.redirect_pc = rpc;
  endtask

  task automatic chk_all(input string p, input logic rv, input logic [31:0] addr, input logic iv,
                         input logic [31:0] d, input logic [31:0] pc, input logic [31:0] pc4,
                         input logic [31:0] cnt, input logic mis);
    chk({p, " req_valid"}, 32'(f.imem_req_valid), 32'(rv));
    chk({p, " req_addr"}, f.imem_req_addr, addr);
    chk({p, " inst_valid"}, 32'(f.inst_valid), 32'(iv));
    chk({p, " inst_data"}, f.inst_data, d);
    chk({p, " inst_pc"}, f.inst_pc, pc);
    chk({p, " inst_pc_plus4"}, f.inst_pc_plus4, pc4);
    chk({p, " fetch_count"}, fetch_count, cnt);
    chk({p, " misalign_err"}, 32'(misalign_err), 32'(mis));
  endtask

  // transaction-level model: phase flags rather than a state encoding
  logic m_booted, m_out, m_have, m_drop, m_mis;
  logic [31:0] m_pc, m_data, m_ipc, m_ipc4, m_cnt;

  task automatic m_reset();
    m_booted = 0; m_out = 0; m_have = 0; m_drop = 0; m_mis = 0;
    m_pc = B; m_data = 0; m_ipc = 0; m_ipc4 = 0; m_cnt = 0;
  endtask

  task automatic m_step();
    logic redir;
    redir = f.redirect_valid;
    if (!m_booted) m_booted = 1;
    else if (m_have) begin
      if (redir || f.inst_ready) m_have = 0;
      if (!redir && f.inst_ready) begin m_pc = m_pc + 4; m_cnt = m_cnt + 1; end
    end else if (m_out) begin
      if (f.imem_rsp_valid) begin
        m_out = 0;
        if (!(m_drop || redir)) begin
          m_have = 1; m_data = f.imem_rsp_data; m_ipc = m_pc; m_ipc4 = m_pc + 4;
        end
        m_drop = 0;
      end else if (redir) m_drop = 1;
    end else if (f.imem_req_ready) begin
      m_out = 1;
      if (redir) m_drop = 1;
    end
    if (redir) m_pc = f.redirect_pc & 32'hFFFFFFFC;
    m_mis = redir && f.redirect_pc[1:0] != 2'b00;
  endtask

  initial begin
    logic [31:0] h1, h2, h3, h4, h5, h6, r;
    h1 = 32'h11111111; h2 = 32'h22222222; h3 = 32'h33333333;
    h4 = 32'h44444444; h5 = 32'h55555555; h6 = 32'h66666666;
    tv.push_back(mk(0,0,0,0,0,0,                    1,B,0,0,0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,                    0,B,0,0,0,0,0,0));
    tv.push_back(mk(0,1,h1,0,0,0,                   0,B,1,h1,B,B+4,0,0));
    tv.push_back(mk(0,0,0,1,0,0,                    1,B+4,0,h1,B,B+4,1,0));
    tv.push_back(mk(1,0,0,0,0,0,                    0,B+4,0,h1,B,B+4,1,0));
    tv.push_back(mk(0,1,h2,0,0,0,                   0,B+4,1,h2,B+4,B+8,1,0));
    tv.push_back(mk(0,0,0,1,0,0,                    1,B+8,0,h2,B+4,B+8,2,0));
    tv.push_back(mk(1,0,0,0,0,0,                    0,B+8,0,h2,B+4,B+8,2,0));
    tv.push_back(mk(0,1,h3,0,0,0,                   0,B+8,1,h3,B+8,B+12,2,0));
    tv.push_back(mk(0,0,0,1,0,0,                    1,B+12,0,h3,B+8,B+12,3,0));
    tv.push_back(mk(1,0,0,0,0,0,                    0,B+12,0,h3,B+8,B+12,3,0));
    tv.push_back(mk(0,1,h4,0,0,0,                   0,B+12,1,h4,B+12,B+16,3,0));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0,0,0,0,0,0,                  0,B+12,1,h4,B+12,B+16,3,0));
    tv.push_back(mk(0,0,0,1,0,0,                    1,B+16,0,h4,B+12,B+16,4,0));
    tv.push_back(mk(1,0,0,0,0,0,                    0,B+16,0,h4,B+12,B+16,4,0));
    tv.push_back(mk(0,0,0,0,1,32'h80000010,         0,32'h80000010,0,h4,B+12,B+16,4,0));
    tv.push_back(mk(0,0,0,0,0,0,                    0,32'h80000010,0,h4,B+12,B+16,4,0));
    tv.push_back(mk(0,1,32'hDEADBEEF,0,0,0,         1,32'h80000010,0,h4,B+12,B+16,4,0));
    tv.push_back(mk(1,0,0,0,0,0,                    0,32'h80000010,0,h4,B+12,B+16,4,0));
    tv.push_back(mk(0,1,h5,0,0,0,                   0,32'h80000010,1,h5,32'h80000010,32'h80000014,4,0));
    tv.push_back(mk(0,0,0,1,1,32'h80000020,         1,32'h80000020,0,h5,32'h80000010,32'h80000014,4,0));
    tv.push_back(mk(0,0,0,0,1,32'h80000013,         1,32'h80000010,0,h5,32'h80000010,32'h80000014,4,1));
    tv.push_back(mk(0,0,0,0,0,0,                    1,32'h80000010,0,h5,32'h80000010,32'h80000014,4,0));
    tv.push_back(mk(0,0,0,0,1,32'hFFFFFFFC,         1,32'hFFFFFFFC,0,h5,32'h80000010,32'h80000014,4,0));
    tv.push_back(mk(1,0,0,0,0,0,                    0,32'hFFFFFFFC,0,h5,32'h80000010,32'h80000014,4,0));
    tv.push_back(mk(0,1,h6,0,0,0,                   0,32'hFFFFFFFC,1,h6,32'hFFFFFFFC,0,4,0));
    tv.push_back(mk(0,0,0,1,0,0,                    1,0,0,h6,32'hFFFFFFFC,0,5,0));

    drive(0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 0, B, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rdy, tv[i].rsp, tv[i].rdata, tv[i].irdy, tv[i].rv, tv[i].rpc);
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("row%0d", i), tv[i].e_rv, tv[i].e_addr, tv[i].e_iv, tv[i].e_data,
              tv[i].e_pc, tv[i].e_pc4, tv[i].e_cnt, tv[i].e_mis);
    end

    // asynchronous reset while a request is outstanding
    drive(1,0,0,0,0,0);
    @(posedge clk);
    @(negedge clk);
    chk("wait req_valid", 32'(f.imem_req_valid), 0);
    drive(0,0,0,0,0,0);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 0, B, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(0,1,32'hBADBAD00,0,0,0);
    @(posedge clk);
    @(negedge clk);
    chk_all("post_rst", 1, B, 0, 0, 0, 0, 0, 0);

    // random run against the model
    drive(0,0,0,0,0,0);
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      chk_all($sformatf("rnd%0d", c), m_booted && !m_out && !m_have, m_pc, m_have,
              m_data, m_ipc, m_ipc4, m_cnt, m_mis);
      r = $urandom;
      drive($urandom_range(0,1) == 1,
            m_out ? ($urandom_range(0,2) == 0) : ($urandom_range(0,15) == 0),
            $urandom, $urandom_range(0,1) == 1, $urandom_range(0,7) == 0,
            (r[3:0] == 0) ? (32'hFFFFFFFC | {30'd0, r[5:4]}) : $urandom);
      @(posedge clk);
      m_step();
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
